// File: rtl/cart_load_ctrl.sv
// Cartridge loader: streams an HPS download into single-port cartridge RAM,
// zero-fills the unused tail, then holds the CPU in reset for a short settle period.
module cart_load_ctrl #(
    parameter int RAM_AW   = 13,
    parameter int HOLD_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic [RAM_AW-1:0] cpu_addr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic [RAM_AW:0]   cart_size,
    output logic              overflow,
    output logic              load_done
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [RAM_AW:0]   FULL     = {1'b1, {RAM_AW{1'b0}}};
    localparam logic [RAM_AW-1:0] LAST     = {RAM_AW{1'b1}};
    localparam logic [HW-1:0]     HOLD_END = HW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CLEAR, HOLD} state_t;

    state_t            state;
    logic              dl_prev;
    logic [RAM_AW-1:0] addr_q;
    logic [HW-1:0]     hold_cnt;

    logic            dl_rise;
    logic            in_range;
    logic [RAM_AW:0] wr_end;

    assign dl_rise  = ioctl_download & ~dl_prev & (ioctl_index == 8'd0);
    assign in_range = (ioctl_addr[24:RAM_AW] == '0);
    assign wr_end   = {1'b0, ioctl_addr[RAM_AW-1:0]} + (RAM_AW+1)'(1);

    // The CPU only sees the RAM while idle; every other state belongs to the loader.
    assign ram_addr = (state == IDLE) ? cpu_addr : addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dl_prev    <= 1'b1;  // a download already high at release must not count as a rise
            addr_q     <= '0;
            hold_cnt   <= '0;
            ioctl_wait <= 1'b0;
            ram_din    <= 8'h00;
            ram_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            cart_size  <= '0;
            overflow   <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            dl_prev    <= ioctl_download;
            ram_we     <= 1'b0;
            ioctl_wait <= 1'b0;
            load_done  <= 1'b0;
            if (dl_rise && (state == IDLE || state == CLEAR || state == HOLD)) begin
                state     <= LOAD;
                cart_size <= '0;
                overflow  <= 1'b0;
                cpu_hold  <= 1'b1;
                addr_q    <= '0;
                hold_cnt  <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        // A fall seen here also covers one deferred from WRITE.
                        if (!ioctl_download) begin
                            hold_cnt <= '0;
                            if (cart_size == FULL) begin
                                state <= HOLD;
                            end else begin
                                state   <= CLEAR;
                                addr_q  <= cart_size[RAM_AW-1:0];
                                ram_din <= 8'h00;
                                ram_we  <= 1'b1;
                            end
                        end else if (ioctl_wr) begin
                            if (in_range) begin
                                state      <= WRITE;
                                addr_q     <= ioctl_addr[RAM_AW-1:0];
                                ram_din    <= ioctl_dout;
                                ram_we     <= 1'b1;
                                ioctl_wait <= 1'b1;
                                if (wr_end > cart_size) cart_size <= wr_end;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    WRITE: state <= LOAD;
                    CLEAR: begin
                        if (addr_q == LAST) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            ram_we <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_END) begin
                            state     <= IDLE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed bench for cart_load_ctrl: a per-cycle vector table plus sequences
// for reset mid-clear, a short load with tail fill, and a full-size load.
module tb_cart_load_ctrl;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic          cpu_hold;
    logic [AW:0]   cart_size;
    logic          overflow;
    logic          load_done;

    cart_load_ctrl #(.RAM_AW(AW), .HOLD_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .cpu_addr(cpu_addr),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .cpu_hold(cpu_hold), .cart_size(cart_size), .overflow(overflow),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];
    int ld_cnt = 0;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    always @(negedge clk) if (load_done) ld_cnt <= ld_cnt + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic [12:0] cpu;
        logic        we;
        logic        wt;
        logic        hold;
        logic [12:0] raddr;
        logic [7:0]  din;
        logic [13:0] size;
        logic        ovf;
    } vec_t;

    vec_t tbl [14];

    initial begin
        //         dl idx wr addr      dout   cpu     we wt hd raddr    din    size    ovf
        tbl[0]  = '{0, 0, 0, 25'h0,    8'h00, 13'h123, 0, 0, 0, 13'h123, 8'h00, 14'h0,  0};
        tbl[1]  = '{1, 1, 0, 25'h0,    8'h00, 13'h055, 0, 0, 0, 13'h055, 8'h00, 14'h0,  0};
        tbl[2]  = '{1, 1, 1, 25'h5,    8'h99, 13'h077, 0, 0, 0, 13'h077, 8'h00, 14'h0,  0};
        tbl[3]  = '{0, 1, 0, 25'h0,    8'h00, 13'h0AA, 0, 0, 0, 13'h0AA, 8'h00, 14'h0,  0};
        tbl[4]  = '{1, 0, 0, 25'h0,    8'h00, 13'h001, 0, 0, 1, 13'h000, 8'h00, 14'h0,  0};
        tbl[5]  = '{1, 0, 1, 25'h10,   8'h5A, 13'h001, 1, 1, 1, 13'h010, 8'h5A, 14'h11, 0};
        tbl[6]  = '{1, 0, 0, 25'h0,    8'h00, 13'h001, 0, 0, 1, 13'h010, 8'h5A, 14'h11, 0};
        tbl[7]  = '{1, 0, 1, 25'h2000, 8'h77, 13'h001, 0, 0, 1, 13'h010, 8'h5A, 14'h11, 1};
        tbl[8]  = '{1, 0, 1, 25'h3,    8'h33, 13'h001, 1, 1, 1, 13'h003, 8'h33, 14'h11, 1};
        tbl[9]  = '{1, 0, 1, 25'h4,    8'h44, 13'h001, 0, 0, 1, 13'h003, 8'h33, 14'h11, 1};
        tbl[10] = '{0, 0, 0, 25'h0,    8'h00, 13'h001, 1, 0, 1, 13'h011, 8'h00, 14'h11, 1};
        tbl[11] = '{0, 0, 0, 25'h0,    8'h00, 13'h001, 1, 0, 1, 13'h012, 8'h00, 14'h11, 1};
        tbl[12] = '{1, 0, 0, 25'h0,    8'h00, 13'h001, 0, 0, 1, 13'h000, 8'h00, 14'h0,  0};
        tbl[13] = '{0, 0, 0, 25'h0,    8'h00, 13'h001, 1, 0, 1, 13'h000, 8'h00, 14'h0,  0};

        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; cpu_addr = '0;
        tick(); tick();
        check("rst_we", ram_we, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_size", cart_size, 0);
        check("rst_ovf", overflow, 0);
        check("rst_din", ram_din, 0);
        check("rst_done", load_done, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            ioctl_download = tbl[i].dl; ioctl_index = tbl[i].idx; ioctl_wr = tbl[i].wr;
            ioctl_addr = tbl[i].addr; ioctl_dout = tbl[i].dout; cpu_addr = tbl[i].cpu;
            tick();
            check($sformatf("v%0d_we", i), ram_we, tbl[i].we);
            check($sformatf("v%0d_wait", i), ioctl_wait, tbl[i].wt);
            check($sformatf("v%0d_hold", i), cpu_hold, tbl[i].hold);
            check($sformatf("v%0d_raddr", i), ram_addr, tbl[i].raddr);
            check($sformatf("v%0d_din", i), ram_din, tbl[i].din);
            check($sformatf("v%0d_size", i), cart_size, tbl[i].size);
            check($sformatf("v%0d_ovf", i), overflow, tbl[i].ovf);
        end
        ioctl_wr = 1'b0;

        // Reset in the middle of CLEAR, with download held high across release.
        cpu_addr = 13'h0BE;
        reset = 1'b1;
        #1;
        check("mid_rst_we", ram_we, 0);
        check("mid_rst_hold", cpu_hold, 0);
        check("mid_rst_size", cart_size, 0);
        check("mid_rst_raddr", ram_addr, 13'h0BE);
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("held_dl_no_load", cpu_hold, 0);
        check("mid_rst_no_done", ld_cnt, 0);

        // Three-byte load: tail must be zero-filled over stale contents.
        for (int a = 0; a < (1<<AW); a++) mem[a] = 8'hEE;
        ioctl_download = 1'b0; tick();
        ioctl_download = 1'b1; tick();
        check("b3_hold_load", cpu_hold, 1);
        for (int i = 0; i < 3; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'hA1 + 8'(i * 8'h11);
            tick();
            ioctl_wr = 1'b0;
            tick();
        end
        check("b3_size", cart_size, 3);
        ioctl_download = 1'b0;
        begin
            int n = 0, hold_low = 0;
            while (!load_done && n < 9000) begin
                tick();
                n++;
                if (!load_done && !cpu_hold) hold_low++;
            end
            check("b3_done_seen", load_done, 1);
            check("b3_hold_gaps", hold_low, 0);
            check("b3_hold_release", cpu_hold, 0);
        end
        tick();
        check("b3_done_count", ld_cnt, 1);
        check("b3_size_idle", cart_size, 3);
        check("b3_ram0", mem[0], 8'hA1);
        check("b3_ram1", mem[1], 8'hB2);
        check("b3_ram2", mem[2], 8'hC3);
        begin
            int bad = 0;
            for (int a = 3; a < (1<<AW); a++) if (mem[a] !== 8'h00) bad++;
            check("b3_tail_zero", bad, 0);
        end

        // Full-size load: no CLEAR, HOLD of 16 clocks.
        ld_cnt = 0;
        ioctl_download = 1'b1; tick();
        for (int a = 0; a < (1<<AW); a++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(a);
            ioctl_dout = 8'(a) ^ 8'(a >> 5);
            tick();
            ioctl_wr = 1'b0;
            tick();
        end
        check("full_size", cart_size, 14'h2000);
        check("full_ovf", overflow, 0);
        ioctl_download = 1'b0;
        tick();
        begin
            int n = 0, wes = 0;
            if (ram_we) wes++;
            while (!load_done && n < 100) begin
                tick();
                n++;
                if (ram_we) wes++;
            end
            check("full_hold_len", n, 16);
            check("full_no_clear", wes, 0);
        end
        tick();
        check("full_done_count", ld_cnt, 1);
        begin
            int bad = 0;
            for (int a = 0; a < (1<<AW); a++)
                if (mem[a] !== (8'(a) ^ 8'(a >> 5))) bad++;
            check("full_ram", bad, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
